// File: rtl/lsu_mem_port.sv
// Load/store port onto a handshaked word bus: 3 cycles accept-to-done at zero wait, 2 for rejects.
// req_ready only in IDLE; bus fields held until mem_ack. LSU_SPLIT_EN builds the two-beat crossing path.
module lsu_mem_port (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        MemRW,
   input  logic [1:0]  WSel,
   input  logic [2:0]  RSel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_DONE} state_t;

   state_t      r_state;
   logic        r_we;
   logic [2:0]  r_rsel;
   logic [1:0]  r_off;
   logic        r_done;
   logic        r_err;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_rdata;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_be;

   logic [3:0]  w_nmask;
   logic        w_legal;
   logic [4:0]  w_sh;
   logic [7:0]  w_span;
   logic        w_cross;
   logic        w_reject;
   logic [31:0] w_raw;
   logic [31:0] w_ext;

   always_comb begin
      w_nmask = 4'h0;
      w_legal = 1'b1;
      if (MemRW) begin
         case (WSel)
            2'b00:   w_nmask = 4'h1;
            2'b01:   w_nmask = 4'h3;
            2'b10:   w_nmask = 4'hF;
            default: w_legal = 1'b0;
         endcase
      end else begin
         case (RSel)
            3'b000, 3'b100: w_nmask = 4'h1;
            3'b010, 3'b101: w_nmask = 4'h3;
            3'b011:         w_nmask = 4'hF;
            default:        w_legal = 1'b0;
         endcase
      end
   end

   // Byte span over two consecutive words: low nibble is beat0 lanes, high nibble beat1 lanes.
   assign w_sh    = {addr[1:0], 3'b000};
   assign w_span  = {4'h0, w_nmask} << addr[1:0];
   assign w_cross = |w_span[7:4];

`ifdef LSU_SPLIT_EN
   logic        r_cross;
   logic [3:0]  r_be_hi;
   logic [31:0] r_wd_hi;
   logic [31:0] r_lo;
   logic [63:0] w_wd;

   assign w_wd     = {32'h0, wdata} << w_sh;
   assign w_reject = !w_legal;
   assign w_raw    = 32'({((r_state == S_BEAT1) ? mem_rdata : 32'h0),
                          ((r_state == S_BEAT1) ? r_lo : mem_rdata)} >> {r_off, 3'b000});
`else
   logic [31:0] w_wd;

   assign w_wd     = wdata << w_sh;
   assign w_reject = !w_legal | w_cross;
   assign w_raw    = mem_rdata >> {r_off, 3'b000};
`endif

   always_comb begin
      w_ext = w_raw;
      case (r_rsel)
         3'b000:  w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
         3'b010:  w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
         3'b100:  w_ext = {24'h0, w_raw[7:0]};
         3'b101:  w_ext = {16'h0, w_raw[15:0]};
         default: w_ext = w_raw;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_rsel      <= 3'b000;
         r_off       <= 2'b00;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= 32'h0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0;
         r_mem_be    <= 4'h0;
         r_mem_wdata <= 32'h0;
`ifdef LSU_SPLIT_EN
         r_cross     <= 1'b0;
         r_be_hi     <= 4'h0;
         r_wd_hi     <= 32'h0;
         r_lo        <= 32'h0;
`endif
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we   <= MemRW;
                  r_rsel <= RSel;
                  r_off  <= addr[1:0];
                  if (w_reject) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                     r_rdata <= 32'h0;
                  end else begin
                     r_state     <= S_BEAT0;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= MemRW;
                     r_mem_addr  <= {addr[31:2], 2'b00};
                     r_mem_be    <= w_span[3:0];
                     r_mem_wdata <= w_wd[31:0];
`ifdef LSU_SPLIT_EN
                     r_cross     <= w_cross;
                     r_be_hi     <= w_span[7:4];
                     r_wd_hi     <= w_wd[63:32];
`endif
                  end
               end
            end
            S_BEAT0: begin
               if (mem_ack) begin
`ifdef LSU_SPLIT_EN
                  if (r_cross) begin
                     // mem_req stays high; the second beat is presented next cycle.
                     r_state     <= S_BEAT1;
                     r_lo        <= mem_rdata;
                     r_mem_addr  <= r_mem_addr + 32'd4;
                     r_mem_be    <= r_be_hi;
                     r_mem_wdata <= r_wd_hi;
                  end else begin
                     r_state   <= S_DONE;
                     r_mem_req <= 1'b0;
                     r_done    <= 1'b1;
                     r_rdata   <= r_we ? 32'h0 : w_ext;
                  end
`else
                  r_state   <= S_DONE;
                  r_mem_req <= 1'b0;
                  r_done    <= 1'b1;
                  r_rdata   <= r_we ? 32'h0 : w_ext;
`endif
               end
            end
`ifdef LSU_SPLIT_EN
            S_BEAT1: begin
               if (mem_ack) begin
                  r_state   <= S_DONE;
                  r_mem_req <= 1'b0;
                  r_done    <= 1'b1;
                  r_rdata   <= r_we ? 32'h0 : w_ext;
               end
            end
`endif
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign rdata     = r_rdata;
   assign done      = r_done;
   assign err       = r_err;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
endmodule
